// File: rtl/clock24_pkg.sv
// Shared types and BCD helpers for the 24-hour timekeeper.
package clock24_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // True when the next increment must land on 00 (limit or illegal digit).
    function automatic logic bcd_wraps(input logic [7:0] v,
                                       input logic [7:0] max);
        return (v >= max) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max);
        logic [7:0] r;
        if (bcd_wraps(v, max))
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/clock24_timekeeper_bcd_cnt.sv
// Two-digit BCD counter with synchronous clear and wrap carry.
module bcd_cnt_mod
    import clock24_pkg::*;
#(
    parameter logic [7:0] MAX  = 8'h59,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] val_o,
    output logic       cy_o
);

    logic [7:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (clr_i)
            val_d = 8'h00;
        else if (inc_i)
            val_d = bcd_inc(val_q, MAX);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            val_q <= INIT;
        else
            val_q <= val_d;
    end

    assign val_o = val_q;
    assign cy_o  = inc_i & ~clr_i & bcd_wraps(val_q, MAX);

endmodule

// File: rtl/clock24_timekeeper.sv
// 24-hour BCD timekeeper with button set mode and 2 Hz field blink.
// Optional alarm compare enabled by defining ALARM_EN.
module clock24_timekeeper
    import clock24_pkg::*;
#(
    parameter logic [7:0] INIT_HOUR = 8'h00,
    parameter logic [7:0] INIT_MIN  = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic       SIG2HZ,
    input  logic       MODE,
    input  logic       UP,
    output logic [7:0] SEC,
    output logic [7:0] MIN,
    output logic [7:0] HOUR,
    output logic       BLANK_MIN,
    output logic       BLANK_HOUR,
    output logic       DAYCARRY
`ifdef ALARM_EN
    ,
    input  logic [7:0] ALM_HOUR,
    input  logic [7:0] ALM_MIN,
    output logic       ALARM
`endif
);

    state_e state_q, state_d;
    logic   dc_q, dc_d;
    logic   run, tick, sec_clr;
    logic   sec_inc, min_inc, hour_inc;
    logic   sec_cy, min_cy, hour_cy;

    always_comb begin
        state_d = state_q;
        if (MODE) begin
            unique case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                default:  state_d = RUN;
            endcase
        end
    end

    // MODE always beats UP and EN1HZ in the same cycle.
    assign run      = (state_q == RUN);
    assign tick     = run & EN1HZ & ~MODE;
    assign sec_clr  = run & MODE;
    assign sec_inc  = tick;
    assign min_inc  = (tick & sec_cy)
                    | ((state_q == SET_MIN) & UP & ~MODE);
    assign hour_inc = (tick & sec_cy & min_cy)
                    | ((state_q == SET_HOUR) & UP & ~MODE);
    assign dc_d     = tick & sec_cy & min_cy & hour_cy;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= RUN;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dc_q    <= dc_d;
        end
    end

    bcd_cnt_mod #(.MAX(SEC_MAX), .INIT(8'h00)) u_sec (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (sec_clr),
        .inc_i  (sec_inc),
        .val_o  (SEC),
        .cy_o   (sec_cy)
    );

    bcd_cnt_mod #(.MAX(MIN_MAX), .INIT(INIT_MIN)) u_min (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (1'b0),
        .inc_i  (min_inc),
        .val_o  (MIN),
        .cy_o   (min_cy)
    );

    bcd_cnt_mod #(.MAX(HOUR_MAX), .INIT(INIT_HOUR)) u_hour (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (1'b0),
        .inc_i  (hour_inc),
        .val_o  (HOUR),
        .cy_o   (hour_cy)
    );

    assign DAYCARRY   = dc_q;
    assign BLANK_HOUR = (state_q == SET_HOUR) & SIG2HZ;
    assign BLANK_MIN  = (state_q == SET_MIN) & SIG2HZ;

`ifdef ALARM_EN
    logic       alarm_q, alarm_d;
    logic [5:0] acnt_q, acnt_d;
    logic [7:0] min_nx, hour_nx;
    logic       hit;

    // Time as it will read after this edge; SEC lands on 00 only via carry.
    assign min_nx  = min_inc ? bcd_inc(MIN, MIN_MAX) : MIN;
    assign hour_nx = hour_inc ? bcd_inc(HOUR, HOUR_MAX) : HOUR;
    assign hit     = tick & sec_cy
                   & (hour_nx == ALM_HOUR) & (min_nx == ALM_MIN);

    always_comb begin
        alarm_d = alarm_q;
        acnt_d  = acnt_q;
        if (MODE | UP) begin
            alarm_d = 1'b0;
        end else if (hit) begin
            alarm_d = 1'b1;
            acnt_d  = 6'd0;
        end else if (alarm_q & tick) begin
            if (acnt_q == 6'd59)
                alarm_d = 1'b0;
            acnt_d = acnt_q + 6'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            alarm_q <= 1'b0;
            acnt_q  <= 6'd0;
        end else begin
            alarm_q <= alarm_d;
            acnt_q  <= acnt_d;
        end
    end

    assign ALARM = alarm_q;
`endif

endmodule

// File: tb/tb_clock24_timekeeper.sv
// Directed scoreboard bench for clock24_timekeeper (INIT 12:34).
module tb_clock24_timekeeper;

    typedef struct {
        string      tag;
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hour;
        logic       dc;
        logic       bh;
        logic       bm;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN1HZ = 1'b0;
    logic       SIG2HZ = 1'b0;
    logic       MODE = 1'b0;
    logic       UP = 1'b0;
    logic [7:0] SEC, MIN, HOUR;
    logic       BLANK_MIN, BLANK_HOUR, DAYCARRY;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    int m_h, m_m, m_s, m_st;
    bit m_dc;

    clock24_timekeeper #(
        .INIT_HOUR(8'h12),
        .INIT_MIN (8'h34)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN1HZ      (EN1HZ),
        .SIG2HZ     (SIG2HZ),
        .MODE       (MODE),
        .UP         (UP),
        .SEC        (SEC),
        .MIN        (MIN),
        .HOUR       (HOUR),
        .BLANK_MIN  (BLANK_MIN),
        .BLANK_HOUR (BLANK_HOUR),
        .DAYCARRY   (DAYCARRY)
    );

    always #10 CLK = ~CLK;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, push and check.
    task automatic cyc(input string tag, input logic rst_n,
                       input logic mo, input logic up, input logic en);
        exp_t e, o;
        logic sig;
        sig    = 1'($urandom_range(0, 1));
        RST    = rst_n;
        MODE   = mo;
        UP     = up;
        EN1HZ  = en;
        SIG2HZ = sig;
        m_dc   = 1'b0;
        if (!rst_n) begin
            m_h = 12; m_m = 34; m_s = 0; m_st = 0;
        end else if (mo) begin
            if (m_st == 0) m_s = 0;
            m_st = (m_st + 1) % 3;
        end else if (m_st == 0) begin
            if (en) begin
                m_s++;
                if (m_s == 60) begin
                    m_s = 0; m_m++;
                    if (m_m == 60) begin
                        m_m = 0; m_h++;
                        if (m_h == 24) begin
                            m_h = 0; m_dc = 1'b1;
                        end
                    end
                end
            end
        end else if (m_st == 1) begin
            if (up) m_h = (m_h + 1) % 24;
        end else begin
            if (up) m_m = (m_m + 1) % 60;
        end
        e.tag  = tag;
        e.sec  = to_bcd(m_s);
        e.min  = to_bcd(m_m);
        e.hour = to_bcd(m_h);
        e.dc   = m_dc;
        e.bh   = (m_st == 1) && sig;
        e.bm   = (m_st == 2) && sig;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        o = sb.pop_front();
        chk({o.tag, ".sec"},  SEC,  o.sec);
        chk({o.tag, ".min"},  MIN,  o.min);
        chk({o.tag, ".hour"}, HOUR, o.hour);
        chk({o.tag, ".dc"},   {7'd0, DAYCARRY},   {7'd0, o.dc});
        chk({o.tag, ".bh"},   {7'd0, BLANK_HOUR}, {7'd0, o.bh});
        chk({o.tag, ".bm"},   {7'd0, BLANK_MIN},  {7'd0, o.bm});
    endtask

    initial begin
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset_hold", 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("idle", 1'b1, 1'b0, 1'b0, 1'b0);
        // Set 23:59 via the buttons, then run up to 23:59:58.
        cyc("to_set_hour", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc("up_hour", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("hour_wrap", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 23; i++) cyc("up_hour2", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("to_set_min", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) cyc("up_min", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("to_run", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 58; i++) cyc("tick", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("tick_59", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("day_roll", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("dc_drop", 1'b1, 1'b0, 1'b0, 1'b0);
        // UP alone ignored in RUN; UP with EN1HZ is a plain tick.
        cyc("run_up", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("run_up_en", 1'b1, 1'b0, 1'b1, 1'b1);
        // Reach 10:20:30.
        cyc("to_set_hour3", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("up_hour3", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("to_set_min3", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc("up_min3", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("to_run3", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cyc("tick3", 1'b1, 1'b0, 1'b0, 1'b1);
        // MODE with EN1HZ: advance, no tick, SEC cleared.
        cyc("mode_en", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("set_en", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("to_set_min4", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) cyc("up60", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("mode_up", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("run_after", 1'b1, 1'b0, 1'b0, 1'b1);
        // Reset mid-edit at MIN=45.
        cyc("to_set_hour5", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("to_set_min5", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) cyc("up_min5", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("rst_edit", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
